pipe_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 4-stage RISC-V pipeline (IF, ID, EX, WB).
- Inputs: ID operand usage, EX instruction class, data-memory handshake and the multi-cycle unit handshake.
- Outputs: per-stage hold, bubble and flush controls.
- Complements the forwarding unit: it resolves the hazards forwarding cannot cover (load-use, memory wait states, multi-cycle ops, taken-branch redirect) and keeps a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 44 ++++
 rtl/stall_perf_counter.sv | 25 ++
 rtl/pipe_stall_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, register-address width, x0 constant,
//           bundled stage-control struct and a source-match helper.
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    // 2'b11 is never entered; it falls back to RUN if ever reached.
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_MC_WAIT  = 2'b10,
        ST_RSVD     = 2'b11
    } ctrl_state_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic flush_id;
        logic bubble_ex;
        logic ex_hold;
    } ctl_t;

    localparam ctl_t CTL_NONE = '{default: 1'b0};
    // Freeze IF/ID/EX; EX/WB takes a bubble.
    localparam ctl_t CTL_HOLD = '{stall_if: 1'b1, stall_id: 1'b1, flush_id: 1'b0,
                                  bubble_ex: 1'b0, ex_hold: 1'b1};
    // Load-use: freeze IF/ID, insert one bubble into EX.
    localparam ctl_t CTL_LUH  = '{stall_if: 1'b1, stall_id: 1'b1, flush_id: 1'b0,
                                  bubble_ex: 1'b1, ex_hold: 1'b0};
    // Taken branch: squash the two younger instructions.
    localparam ctl_t CTL_FLUSH = '{stall_if: 1'b0, stall_id: 1'b0, flush_id: 1'b1,
                                   bubble_ex: 1'b1, ex_hold: 1'b0};

    function automatic logic reads_src(input logic used,
                                       input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
// Latency: count reflects an event on the following edge.
// Backpressure: none; sticks at all-ones instead of wrapping.
// Ports: clk/rstn, clr (sync clear), inc (count this cycle), cnt (value).
module stall_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX/WB pipeline: load-use, memory wait,
// multi-cycle wait with timeout, taken-branch flush, stall-cycle counter.
// Latency: stage controls and dmem_req are combinational; mc_err one cycle late.
// Ports: ID operand usage, EX class/handshakes in; per-stage hold/bubble/flush,
//        dmem_req, mc_err, state_o and the saturating stall_cnt out.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_wr,
    input  logic              ex_is_load,
    input  logic              ex_is_mem,
    input  logic              ex_mc_start,
    input  logic              ex_branch_taken,
    input  logic              dmem_ack,
    input  logic              mc_done,
    input  logic              perf_clr,
    output logic              dmem_req,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic              ex_hold,
    output logic              mc_err,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int                  MC_CNT_W = 16;
    localparam logic [MC_CNT_W-1:0] MC_LAST  = MC_CNT_W'(MC_TIMEOUT - 1);

    ctrl_state_t         state_q, state_d;
    logic [MC_CNT_W-1:0] mc_cnt;
    logic                mc_err_q;
    logic                ex_v, luh, mc_timeout, mc_enter;
    ctl_t                ctl;

    // Upstream reset also squashes EX, so gating here lets every
    // combinational output fall to zero the moment rstn drops.
    assign ex_v = ex_valid & rstn;

    assign luh = id_valid && ex_v && ex_is_load && ex_reg_wr && (ex_rd != ZERO_REG) &&
                 (reads_src(id_rs1_used, id_rs1, ex_rd) ||
                  reads_src(id_rs2_used, id_rs2, ex_rd));

    // mc_done arriving on the last allowed cycle is a normal completion.
    assign mc_timeout = (state_q == ST_MC_WAIT) && !mc_done && (mc_cnt == MC_LAST);
    assign mc_enter   = (state_q == ST_RUN) && (state_d == ST_MC_WAIT);

    // State register and wait-cycle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_RUN;
            mc_cnt   <= '0;
            mc_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mc_err_q <= mc_timeout;
            if (mc_enter) begin
                mc_cnt <= '0;
            end else if (state_q == ST_MC_WAIT) begin
                mc_cnt <= mc_cnt + MC_CNT_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (ex_v) begin
                    if (ex_is_mem && !dmem_ack) begin
                        state_d = ST_MEM_WAIT;
                    end else if (ex_mc_start) begin
                        state_d = ST_MC_WAIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // Losing ex_valid mid-wait is a protocol error; just recover.
                if (!ex_v || dmem_ack) begin
                    state_d = ST_RUN;
                end
            end
            ST_MC_WAIT: begin
                if (mc_done || mc_timeout) begin
                    state_d = ST_RUN;
                end
            end
            ST_RSVD: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Output logic.
    always_comb begin
        ctl      = CTL_NONE;
        dmem_req = ex_v && ex_is_mem && (state_q != ST_MC_WAIT);
        case (state_q)
            ST_RUN: begin
                if (ex_v) begin
                    if (ex_is_mem && !dmem_ack) begin
                        ctl = CTL_HOLD;
                    end else if (ex_mc_start) begin
                        ctl = CTL_HOLD;
                    end else if (ex_branch_taken) begin
                        ctl = CTL_FLUSH;
                    end else if (luh) begin
                        ctl = CTL_LUH;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (ex_v) begin
                    if (!dmem_ack) begin
                        ctl = CTL_HOLD;
                    end else if (luh) begin
                        ctl = CTL_LUH;
                    end
                end
            end
            ST_MC_WAIT: begin
                if (!(mc_done || mc_timeout)) begin
                    ctl = CTL_HOLD;
                end
            end
            default: ctl = CTL_NONE;
        endcase
    end

    assign stall_if  = ctl.stall_if;
    assign stall_id  = ctl.stall_id;
    assign flush_id  = ctl.flush_id;
    assign bubble_ex = ctl.bubble_ex;
    assign ex_hold   = ctl.ex_hold;
    assign mc_err    = mc_err_q;
    assign state_o   = state_q;

    stall_perf_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (perf_clr),
        .inc  (stall_if),
        .cnt  (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 6;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       ex_valid = 1'b0, ex_reg_wr = 1'b0, ex_is_load = 1'b0, ex_is_mem = 1'b0;
    logic       ex_mc_start = 1'b0, ex_branch_taken = 1'b0;
    logic       dmem_ack = 1'b0, mc_done = 1'b0, perf_clr = 1'b0;

    logic             dmem_req, stall_if, stall_id, flush_id, bubble_ex, ex_hold, mc_err;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stall_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .ex_is_load(ex_is_load), .ex_is_mem(ex_is_mem), .ex_mc_start(ex_mc_start),
        .ex_branch_taken(ex_branch_taken), .dmem_ack(dmem_ack), .mc_done(mc_done),
        .perf_clr(perf_clr), .dmem_req(dmem_req), .stall_if(stall_if),
        .stall_id(stall_id), .flush_id(flush_id), .bubble_ex(bubble_ex),
        .ex_hold(ex_hold), .mc_err(mc_err), .state_o(state_o), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Mode: 0 running, 1 waiting for memory, 2 waiting for multi-cycle unit.
    int m_mode   = 0;
    int m_waited = 0;   // multi-cycle wait cycles already spent
    int m_cnt    = 0;
    bit m_err    = 1'b0;
    bit chk_on   = 1'b0;

    typedef struct {
        bit dmem_req, stall_if, stall_id, flush_id, bubble_ex, ex_hold, timeout;
        int next_mode;
    } exp_t;

    function automatic exp_t model_eval();
        exp_t e;
        bit ev, hz, hold, lu;
        ev = ex_valid && rstn;
        hz = ev && id_valid && ex_is_load && ex_reg_wr && (ex_rd != 0) &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        hold = 0; lu = 0;
        e.flush_id = 0; e.timeout = 0; e.next_mode = m_mode;
        e.dmem_req = ev && ex_is_mem && (m_mode != 2);
        if (!rstn) begin
            e.next_mode = 0;
        end else if (m_mode == 0) begin
            if (ev && ex_is_mem && !dmem_ack) begin hold = 1; e.next_mode = 1; end
            else if (ev && ex_mc_start)        begin hold = 1; e.next_mode = 2; end
            else if (ev && ex_branch_taken)    e.flush_id = 1;
            else                               lu = hz;
        end else if (m_mode == 1) begin
            if (!ev)            e.next_mode = 0;
            else if (!dmem_ack) hold = 1;
            else begin lu = hz; e.next_mode = 0; end
        end else begin
            if (mc_done) e.next_mode = 0;
            else if (m_waited == MC_TIMEOUT - 1) begin e.timeout = 1; e.next_mode = 0; end
            else hold = 1;
        end
        e.stall_if  = hold || lu;
        e.stall_id  = hold || lu;
        e.ex_hold   = hold;
        e.bubble_ex = lu || e.flush_id;
        return e;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_mode <= 0; m_waited <= 0; m_cnt <= 0; m_err <= 1'b0;
        end else begin
            automatic exp_t e = model_eval();
            if (perf_clr)                         m_cnt <= 0;
            else if (e.stall_if && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
            m_err <= e.timeout;
            if (m_mode != 2)                      m_waited <= 0;
            else                                  m_waited <= m_waited + 1;
            m_mode <= e.next_mode;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            automatic exp_t e = model_eval();
            check("dmem_req",  dmem_req,  e.dmem_req);
            check("stall_if",  stall_if,  e.stall_if);
            check("stall_id",  stall_id,  e.stall_id);
            check("flush_id",  flush_id,  e.flush_id);
            check("bubble_ex", bubble_ex, e.bubble_ex);
            check("ex_hold",   ex_hold,   e.ex_hold);
            check("mc_err",    mc_err,    m_err);
            check("state_o",   state_o,   m_mode);
            check("stall_cnt", stall_cnt, m_cnt);
            check("flush_vs_stall", flush_id & stall_id, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_valid = 0; ex_rd = 0; ex_reg_wr = 0; ex_is_load = 0; ex_is_mem = 0;
        ex_mc_start = 0; ex_branch_taken = 0; dmem_ack = 0; mc_done = 0; perf_clr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mc_run(input string tag, input int done_at, input int last,
                          input int exp_holds, input bit exp_err);
        int holds;
        holds = 0;
        set_idle();
        ex_valid = 1; ex_mc_start = 1; ex_reg_wr = 1; ex_rd = 9;
        for (int i = 0; i <= last; i++) begin
            mc_done = (i == done_at);
            @(negedge clk);
            holds += int'(ex_hold);
            if (i == last) begin
                check({tag, "_release"}, ex_hold, 0);
                check({tag, "_state"}, state_o, 2'b10);
                check({tag, "_err_not_yet"}, mc_err, 0);
            end
            cyc();
        end
        set_idle();
        @(negedge clk);
        check({tag, "_holds"}, holds, exp_holds);
        check({tag, "_err"}, mc_err, exp_err);
        check({tag, "_back_run"}, state_o, 0);
        cyc();
        @(negedge clk);
        check({tag, "_err_gone"}, mc_err, 0);
        cyc();
    endtask

    initial begin
        int n_req, n_hold, n_mw;
        set_idle();
        chk_on = 1;
        repeat (2) cyc();
        check("rst_state", state_o, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_err", mc_err, 0);
        check("rst_stall_if", stall_if, 0);
        rstn = 1;
        cyc();

        // load-use with same-cycle ack: one bubble only
        ex_valid = 1; ex_is_load = 1; ex_is_mem = 1; ex_reg_wr = 1; ex_rd = 5; dmem_ack = 1;
        id_valid = 1; id_rs1 = 5; id_rs1_used = 1; id_rs2 = 1; id_rs2_used = 1;
        @(negedge clk);
        check("luh_stall_if", stall_if, 1);
        check("luh_stall_id", stall_id, 1);
        check("luh_bubble", bubble_ex, 1);
        check("luh_no_hold", ex_hold, 0);
        cyc();
        set_idle(); ex_valid = 1; ex_reg_wr = 1; ex_rd = 6; id_valid = 1;
        @(negedge clk);
        check("luh_one_bubble", stall_if, 0);
        cyc();
        // x0 destination never stalls
        set_idle(); ex_valid = 1; ex_is_load = 1; ex_is_mem = 1; ex_reg_wr = 1; dmem_ack = 1;
        id_valid = 1; id_rs1_used = 1;
        @(negedge clk);
        check("x0_no_stall", stall_if, 0);
        check("x0_no_bubble", bubble_ex, 0);
        cyc();

        // memory wait, ack on 4th cycle
        set_idle(); perf_clr = 1;
        cyc();
        perf_clr = 0; ex_valid = 1; ex_is_mem = 1;
        n_req = 0; n_hold = 0; n_mw = 0;
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            @(negedge clk);
            n_req += int'(dmem_req); n_hold += int'(ex_hold); n_mw += int'(state_o == 2'b01);
            cyc();
        end
        set_idle();
        @(negedge clk);
        check("mw_req_cycles", n_req, 4);
        check("mw_hold_cycles", n_hold, 3);
        check("mw_state_cycles", n_mw, 3);
        check("mw_stall_cnt", stall_cnt, 3);
        check("mw_model_cnt", m_cnt, 3);
        cyc();

        // multi-cycle: done on 5th wait cycle, timeout, coincident done
        mc_run("mc_done", 5, 5, 5, 1'b0);
        mc_run("mc_tmo", 99, MC_TIMEOUT, MC_TIMEOUT, 1'b1);
        mc_run("mc_both", MC_TIMEOUT, MC_TIMEOUT, MC_TIMEOUT, 1'b0);

        // taken branch dominates a load-use match
        set_idle(); ex_valid = 1; ex_branch_taken = 1; ex_is_load = 1; ex_is_mem = 1;
        ex_reg_wr = 1; ex_rd = 7; dmem_ack = 1; id_valid = 1; id_rs1 = 7; id_rs1_used = 1;
        @(negedge clk);
        check("br_flush", flush_id, 1);
        check("br_bubble", bubble_ex, 1);
        check("br_stall_id", stall_id, 0);
        check("br_stall_if", stall_if, 0);
        cyc();

        // saturation, then clear during a stall
        set_idle(); perf_clr = 1;
        cyc();
        perf_clr = 0; ex_valid = 1; ex_is_mem = 1;
        repeat (70) cyc();
        @(negedge clk);
        check("sat_cnt", stall_cnt, CNT_MAX);
        cyc();
        perf_clr = 1;
        cyc();
        perf_clr = 0;
        @(negedge clk);
        check("clr_cnt", stall_cnt, 0);
        check("clr_still_stall", stall_if, 1);
        cyc();

        // asynchronous reset in the middle of a memory wait
        check("pre_rst_state", state_o, 2'b01);
        #2 rstn = 0;
        #1;
        check("arst_state", state_o, 0);
        check("arst_req", dmem_req, 0);
        check("arst_stall", stall_if, 0);
        check("arst_hold", ex_hold, 0);
        check("arst_cnt", stall_cnt, 0);
        cyc();
        rstn = 1; set_idle();
        cyc();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rstn = ($urandom_range(0, 399) != 0);
            perf_clr = ($urandom_range(0, 49) == 0);
            if (m_mode == 0) begin
                id_valid = $urandom_range(0, 3) != 0;
                id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
                id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
                ex_valid = $urandom_range(0, 3) != 0;
                ex_rd = 5'($urandom_range(0, 3)); ex_reg_wr = 1'($urandom);
                ex_is_mem = $urandom_range(0, 9) < 3;
                ex_is_load = ex_is_mem && 1'($urandom);
                ex_mc_start = $urandom_range(0, 9) < 2;
                ex_branch_taken = $urandom_range(0, 9) < 2;
                dmem_ack = 1'($urandom);
                mc_done = $urandom_range(0, 9) == 0;
            end else if (m_mode == 1) begin
                dmem_ack = $urandom_range(0, 9) < 3;
                if ($urandom_range(0, 19) == 0) ex_valid = 0;
            end else begin
                mc_done = $urandom_range(0, 19) < 3;
            end
            cyc();
        end

        set_idle(); rstn = 1;
        cyc();
        @(negedge clk);
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
